// File: rtl/weight_mem_arb.sv
// Round-robin arbiter/sequencer for the shared weight-memory read port.
// Optional watchdog: define WARB_TIMEOUT_EN to enable the WAIT timeout and err flag.
module weight_mem_arb #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic                      mem_rd_req,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic                      mem_ready,
  input  logic [511:0]              mem_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [511:0]              rsp_data,
`ifdef WARB_TIMEOUT_EN
  output logic                      busy,
  output logic                      err
`else
  output logic                      busy
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PW-1:0]       r_ptr;
  logic [PW-1:0]       r_owner;
  logic [PW-1:0]       w_win;
  logic [PW-1:0]       w_owner_inc;
  logic                w_any;
  logic                w_timeout;
  logic [NUM_REQ-1:0]  r_grant;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr;
  logic [511:0]        r_data;

  // Lowest index below the pointer is the fallback; any set bit at or
  // above the pointer overrides it, giving a wrap-around scan.
  always_comb begin
    w_win  = r_ptr;
    w_addr = '0;
    w_any  = |req;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (PW'(j) < r_ptr))
        w_win = PW'(j);
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req[j] && (PW'(j) >= r_ptr))
        w_win = PW'(j);
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (PW'(j) == w_win)
        w_addr = req_addr[j*ADDR_W +: ADDR_W];
    end
  end

  assign w_win_oh    = NUM_REQ'(1) << w_win;
  assign w_owner_inc = (r_owner == PW'(NUM_REQ - 1)) ? '0
                                                      : r_owner + PW'(1);

`ifdef WARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_timeout = (r_state == S_WAIT) && !mem_ready
                     && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_next == S_ISSUE)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + CW'(1);
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (mem_ready)
          w_next = S_RESP;
        else if (w_timeout)
          w_next = S_IDLE;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any) begin
        r_grant <= w_win_oh;
        r_owner <= w_win;
        r_addr  <= w_addr;
      end
      if ((r_state == S_WAIT) && mem_ready)
        r_data <= mem_data;
      // Normal completion and watchdog abort both rotate past the owner.
      if ((r_state == S_RESP) || w_timeout) begin
        r_grant <= '0;
        r_ptr   <= w_owner_inc;
      end
    end
  end

  assign mem_rd_req  = (r_state == S_ISSUE);
  assign mem_rd_addr = r_addr;
  assign grant       = r_grant;
  assign rsp_valid   = (r_state == S_RESP) ? r_grant : '0;
  assign rsp_data    = r_data;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_weight_mem_arb.sv
// Directed testbench for weight_mem_arb (3 loaders, TIMEOUT=16).
// Build with WARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_weight_mem_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic [95:0]  req_addr;
  logic         mem_rd_req;
  logic [31:0]  mem_rd_addr;
  logic         mem_ready;
  logic [511:0] mem_data;
  logic [2:0]   grant;
  logic [2:0]   rsp_valid;
  logic [511:0] rsp_data;
  logic         busy;
`ifdef WARB_TIMEOUT_EN
  logic         err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  weight_mem_arb #(
    .NUM_REQ(3),
    .ADDR_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .mem_rd_req (mem_rd_req),
    .mem_rd_addr(mem_rd_addr),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
`ifdef WARB_TIMEOUT_EN
    .busy       (busy),
    .err        (err)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] pat(input int k);
    return {16{32'hA5000000 | 32'(k)}};
  endfunction

  // Runs one transaction from IDLE; returns what the bus showed.
  task automatic run_txn(input logic [511:0] d, output logic [2:0] g,
                         output logic [2:0] rv, output logic [511:0] rd);
    int k;
    g  = '0;
    rv = '0;
    rd = '0;
    for (k = 0; k < 20; k++) begin
      if (mem_rd_req) break;
      tick();
    end
    if (k == 20) begin
      n_tests++;
      n_fail++;
      $display("FAIL txn_strobe_timeout: no mem_rd_req within 20 cycles");
      return;
    end
    g = grant;
    tick();
    mem_ready = 1'b1;
    mem_data  = d;
    tick();
    mem_ready = 1'b0;
    rv = rsp_valid;
    rd = rsp_data;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; mem_ready = 1'b0; mem_data = '0;
    req_addr = {32'h300, 32'h100, 32'h200};
    tick(); tick();
    n_tests++;
    if ({grant, rsp_valid, mem_rd_req, busy} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 0",
               {grant, rsp_valid, mem_rd_req, busy});
    end
    n_tests++;
    if (mem_rd_addr !== 32'h0 || rsp_data !== 512'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h data_lo %h want 0",
               mem_rd_addr, rsp_data[63:0]);
    end
`ifdef WARB_TIMEOUT_EN
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", err);
    end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [2:0]   exp_g [6] = '{3'b001, 3'b010, 3'b100,
                                3'b001, 3'b010, 3'b100};
    logic [2:0]   g, rv;
    logic [511:0] rd;
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      run_txn(pat(t), g, rv, rd);
      n_tests++;
      if (g !== exp_g[t]) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got %b want %b", t, g, exp_g[t]);
      end
      n_tests++;
      if (rv !== exp_g[t] || rd !== pat(t)) begin
        n_fail++;
        $display("FAIL contention_rsp%0d: rv %b want %b data %h want %h",
                 t, rv, exp_g[t], rd[63:0], pat(t)[63:0]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_single();
    int strobes;
    req = 3'b010;
    tick();
    n_tests++;
    if (grant !== 3'b010 || mem_rd_req !== 1'b1 || mem_rd_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL single_issue: grant %b rd %b addr %h want 010 1 100",
               grant, mem_rd_req, mem_rd_addr);
    end
    strobes = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_rd_req) strobes++;
    end
    tick();
    mem_ready = 1'b1;
    mem_data  = pat(77);
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (strobes !== 0 || mem_rd_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL single_hold: extra strobes %0d addr %h want 0 100",
               strobes, mem_rd_addr);
    end
    n_tests++;
    if (rsp_valid !== 3'b010 || rsp_data !== pat(77)) begin
      n_fail++;
      $display("FAIL single_rsp: rv %b data %h want 010 %h",
               rsp_valid, rsp_data[63:0], pat(77)[63:0]);
    end
    req = '0;
    tick();
    n_tests++;
    if (busy !== 1'b0 || grant !== 3'b0 || rsp_valid !== 3'b0
        || rsp_data !== pat(77)) begin
      n_fail++;
      $display("FAIL single_idle: busy %b grant %b rv %b want 0 0 0",
               busy, grant, rsp_valid);
    end
  endtask

  // Pointer sits at 2 here.
  task automatic test_owner_drop();
    req = 3'b101;
    tick();
    n_tests++;
    if (grant !== 3'b100) begin
      n_fail++;
      $display("FAIL drop_grant: got %b want 100", grant);
    end
    tick();
    req = 3'b001;
    tick();
    mem_ready = 1'b1;
    mem_data  = pat(5);
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 3'b100) begin
      n_fail++;
      $display("FAIL drop_rsp: got %b want 100", rsp_valid);
    end
    tick();
    tick();
    n_tests++;
    if (grant !== 3'b001) begin
      n_fail++;
      $display("FAIL drop_next: got %b want 001", grant);
    end
    tick();
    mem_ready = 1'b1;
    mem_data  = pat(6);
    tick();
    mem_ready = 1'b0;
    req = '0;
    tick();
  endtask

  // Pointer sits at 1 here; rsp_data holds pat(6).
  task automatic test_spurious();
    mem_ready = 1'b1;
    mem_data  = pat(99);
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 3'b0 || rsp_data !== pat(6)) begin
      n_fail++;
      $display("FAIL spur_idle: busy %b rv %b data %h want 0 0 %h",
               busy, rsp_valid, rsp_data[63:0], pat(6)[63:0]);
    end
    req = 3'b010;
    tick();
    mem_ready = 1'b1;
    mem_data  = pat(98);
    tick();
    mem_ready = 1'b0;
    tick();
    n_tests++;
    if (busy !== 1'b1 || mem_rd_req !== 1'b0 || rsp_valid !== 3'b0
        || rsp_data !== pat(6)) begin
      n_fail++;
      $display("FAIL spur_issue: busy %b rd %b rv %b data %h want 1 0 0 %h",
               busy, mem_rd_req, rsp_valid, rsp_data[63:0], pat(6)[63:0]);
    end
    mem_ready = 1'b1;
    mem_data  = pat(7);
    tick();
    mem_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 3'b010 || rsp_data !== pat(7)) begin
      n_fail++;
      $display("FAIL spur_rsp: rv %b data %h want 010 %h",
               rsp_valid, rsp_data[63:0], pat(7)[63:0]);
    end
    req = '0;
    tick();
  endtask

  // Pointer sits at 2 here.
  task automatic test_reset_mid_wait();
    req = 3'b001;
    tick();
    tick();
    rst = 1'b1;
    req = '0;
    #1;
    n_tests++;
    if ({grant, rsp_valid, mem_rd_req, busy} !== 8'h0
        || mem_rd_addr !== 32'h0 || rsp_data !== 512'h0) begin
      n_fail++;
      $display("FAIL rst_async: grant %b busy %b addr %h want 0 0 0",
               grant, busy, mem_rd_addr);
    end
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_data  = pat(55);
    tick();
    mem_ready = 1'b0;
    tick();
    n_tests++;
    if (rsp_valid !== 3'b0 || busy !== 1'b0 || rsp_data !== 512'h0) begin
      n_fail++;
      $display("FAIL rst_ignore: rv %b busy %b data %h want 0 0 0",
               rsp_valid, busy, rsp_data[63:0]);
    end
    req = 3'b111;
    tick();
    n_tests++;
    if (grant !== 3'b001) begin
      n_fail++;
      $display("FAIL rst_ptr: got %b want 001", grant);
    end
    tick();
    mem_ready = 1'b1;
    mem_data  = pat(8);
    tick();
    mem_ready = 1'b0;
    req = '0;
    tick();
  endtask

`ifdef WARB_TIMEOUT_EN
  // Pointer sits at 1 here.
  task automatic test_timeout();
    int rv_seen;
    req = 3'b010;
    tick();
    tick();
    rv_seen = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (rsp_valid != 3'b0) rv_seen++;
    end
    n_tests++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL to_early: busy %b err %b want 1 0", busy, err);
    end
    req = 3'b011;
    tick();
    n_tests++;
    if (busy !== 1'b0 || err !== 1'b1 || grant !== 3'b0 || rv_seen !== 0) begin
      n_fail++;
      $display("FAIL to_fire: busy %b err %b grant %b rv %0d want 0 1 0 0",
               busy, err, grant, rv_seen);
    end
    tick();
    n_tests++;
    if (grant !== 3'b001) begin
      n_fail++;
      $display("FAIL to_skip: got %b want 001", grant);
    end
    tick();
    mem_ready = 1'b1;
    mem_data  = pat(9);
    tick();
    mem_ready = 1'b0;
    req = '0;
    tick();
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL to_sticky: got %b want 1", err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_owner_drop();
    test_spurious();
    test_reset_mid_wait();
`ifdef WARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_mem_arb.md
# weight_mem_arb

Round-robin arbiter and sequencer for the single shared weight-memory read port. It sits between the per-network weight loaders (rotation network, detection network, and others) and the memory interface. It grants one requester at a time, issues one line read per grant, and returns the 8×64-bit line to the granted loader only. It replaces point-to-point `req_mem`/`mem_ready` wiring so that several loaders can fill their weights concurrently without bus contention.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesting loaders, 2..8.
- `ADDR_W`, 32: line address width.
- `TIMEOUT`, 1024: watchdog limit in cycles. Used only with `WARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request per loader; held until that loader sees its `rsp_valid`.
- `req_addr`  in  ADDR_W × NUM_REQ  line address per loader; sampled at grant.
- `mem_rd_req`  out  1  one-cycle read strobe to memory.
- `mem_rd_addr`  out  ADDR_W  address for the strobe; held stable until `mem_ready`.
- `mem_ready`  in  1  one-cycle pulse: `mem_data` valid this cycle.
- `mem_data`  in  64 × 8  returned line.
- `grant`  out  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- `rsp_valid`  out  NUM_REQ  one-cycle pulse to the owner only.
- `rsp_data`  out  64 × 8  registered copy of the line; shared by all loaders.
- `busy`  out  1  high in any state other than IDLE.
- `err`  out  1  sticky watchdog flag. Present only with `WARB_TIMEOUT_EN`.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE
  - If any `req` bit is set, select the winner: the first set bit at or after `rr_ptr`, scanning upward and wrapping modulo `NUM_REQ`.
  - Register `grant` (one-hot), latch `req_addr[winner]` into `mem_rd_addr`, go to ISSUE.
  - If no `req` bit is set, stay in IDLE with all outputs at their idle values.
- ISSUE: `mem_rd_req`=1 for exactly this cycle; go to WAIT.
- WAIT
  - Hold `grant` and `mem_rd_addr`.
  - On `mem_ready`=1, register `mem_data` into `rsp_data`, go to RESP.
  - `mem_ready` in any state other than WAIT is ignored; no data is captured.
- RESP
  - `rsp_valid[owner]`=1 for this cycle.
  - `rr_ptr` ← (owner+1) mod `NUM_REQ`.
  - Clear `grant`, go to IDLE.
- Owner deasserting `req` during ISSUE or WAIT: the transaction still completes and `rsp_valid` still pulses. Arbitration never aborts a read once it is issued.
- Non-owner `req` changes while `busy`=1 have no effect until the next IDLE.
- Fairness: after a grant to loader k, every other pending loader is served before k is served again.
- `rsp_data` keeps its value until the next capture.

## Timing
- Reset values: `grant`=0, `rsp_valid`=0, `mem_rd_req`=0, `mem_rd_addr`=0, `rsp_data`=all zeros, `busy`=0, `err`=0, `rr_ptr`=0, state IDLE.
- Reset is asynchronous: asserting `rst` mid-transaction returns to IDLE immediately. A `mem_ready` arriving after reset is released is ignored because the block is no longer in WAIT.
- Latency, with `req` first seen high in IDLE cycle N:
  - `grant` is visible from cycle N+1.
  - `mem_rd_req` is high in cycle N+1.
  - If `mem_ready` arrives in cycle M ≥ N+2, `rsp_valid` is high in cycle M+1 and IDLE is re-entered in cycle M+2.
- Minimum transaction is 4 cycles (`mem_ready` in the first WAIT cycle).
- Turnaround: the loader registers `rsp_valid` and drops `req` at the same edge that enters IDLE, so its stale `req` is never re-sampled.
- `rsp_data` is valid in the `rsp_valid` cycle and afterwards.

## Configuration
- `WARB_TIMEOUT_EN` defined:
  - A counter increments each cycle in WAIT.
  - When the counter reaches `TIMEOUT`-1 without `mem_ready`: set `err`=1 (sticky until `rst`), go directly to IDLE, clear `grant`, advance `rr_ptr` past the owner, and emit no `rsp_valid`.
  - The counter clears on entry to ISSUE.
- `WARB_TIMEOUT_EN` undefined: no counter and no `err` port. WAIT lasts until `mem_ready`.

## Test plan
- Single requester: `req`=3'b010 with addr 0x100; `mem_ready` 5 cycles after the strobe.
  - Expect one `mem_rd_req` with `mem_rd_addr`=0x100 and `grant`=3'b010.
  - Expect `rsp_valid`=3'b010 one cycle after `mem_ready`, with `rsp_data` equal to `mem_data`.
- Contention: all three `req` bits held for 6 transactions.
  - Expect grant order 0,1,2,0,1,2.
  - Expect no `rsp_valid` bit on any non-owner.
- Owner drops `req` during WAIT: `rsp_valid` still pulses for that owner, and the next grant goes to the following pending loader.
- Spurious `mem_ready` in IDLE and in ISSUE: no state change and `rsp_data` unchanged.
- Reset mid-WAIT: assert `rst` for 1 cycle, then pulse `mem_ready`.
  - Expect all outputs at reset values and no `rsp_valid`.
  - Expect `rr_ptr`=0, so the next contended grant goes to loader 0.
- With `WARB_TIMEOUT_EN` and `TIMEOUT`=16: withhold `mem_ready`.
  - Expect `err`=1 and return to IDLE 16 cycles after entering WAIT.
  - Expect the next grant to skip the timed-out loader.
